pipe_hazard_ctrl: RTL and testbench

Central sequencer for the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It detects load-use hazards and generates the stall and bubble controls for them. It also runs the precise-exception / interrupt / ERET flush-and-redirect sequence from MEM/WB-stage status (valid, overflow, EXCCODE, OPC). It owns EPC/Cause capture and drives the PC-source select.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/hazard_detect.sv | 15 +
 rtl/pipe_hazard_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline hazard / exception sequencer.
package pipe_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t RUN      = 2'd0;
  localparam state_t FLUSH    = 2'd1;
  localparam state_t REDIRECT = 2'd2;

  localparam logic [1:0] PC_SEQ     = 2'b00;
  localparam logic [1:0] PC_HANDLER = 2'b01;
  localparam logic [1:0] PC_EPC     = 2'b10;

  localparam logic [4:0]  EXC_OV      = 5'd12;
  localparam logic [4:0]  EXC_INT     = 5'd0;
  localparam logic [31:0] HANDLER_VEC = 32'h0000_4180;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in ID/EX whose destination feeds the instruction in ID.
module hazard_detect (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [2:0] id_ex_memread,
  input  logic [4:0] id_ex_rt,
  output logic       load_use
);

  always_comb begin
    load_use = (id_ex_memread != 3'd0) && (id_ex_rt != 5'd0) &&
               ((id_ex_rt == id_rs) || (id_ex_rt == id_rt));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush sequencer with precise exception, interrupt and ERET handling.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HANDLER_VEC,
  parameter int          FLUSH_CYCLES = 1,
  parameter logic [4:0]  EXC_OV_CODE  = EXC_OV,
  parameter logic [4:0]  EXC_INT_CODE = EXC_INT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [2:0]  id_ex_memread,
  input  logic [4:0]  id_ex_rt,
  input  logic        mem_wb_valid,
  input  logic        mem_wb_overflow,
  input  logic [4:0]  mem_wb_exccode,
  input  logic [31:0] mem_wb_opc,
  input  logic        mem_wb_eret,
  input  logic        irq,
  output logic        stall_pc,
  output logic        stall_if_id,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        flush_ex_mem,
  output logic        flush_mem_wb,
  output logic        wb_kill,
  output logic [1:0]  pc_sel,
  output logic [31:0] epc_out,
  output logic [4:0]  cause_out,
  output logic        busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] exc_cnt
`endif
);

  // The PC mux lives outside this block, so the vector is only sanity-checked here.
  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
    $error("pipe_hazard_ctrl: FLUSH_CYCLES must be in 1..7");
  end
  if (HANDLER_ADDR[1:0] != 2'b00) begin : g_bad_handler_addr
    $error("pipe_hazard_ctrl: HANDLER_ADDR must be word aligned");
  end

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  state_t     state;
  logic [2:0] flush_cnt;
  logic       irq_pend;
  logic       load_use_raw;
  logic       exc_now, int_now, eret_now, lu_now;

  hazard_detect u_hazard_detect (
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_ex_memread (id_ex_memread),
    .id_ex_rt      (id_ex_rt),
    .load_use      (load_use_raw)
  );

  always_comb begin
    exc_now  = (state == RUN) && mem_wb_valid &&
               (mem_wb_overflow || (mem_wb_exccode != 5'd0));
    int_now  = (state == RUN) && mem_wb_valid && irq_pend && !exc_now;
    eret_now = (state == RUN) && mem_wb_eret && !exc_now && !int_now;
    lu_now   = (state == RUN) && load_use_raw && !exc_now && !int_now && !mem_wb_eret;
  end

  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    flush_mem_wb = 1'b0;
    wb_kill      = 1'b0;
    pc_sel       = PC_SEQ;
    busy         = (state != RUN);
    case (state)
      RUN: begin
        if (exc_now || int_now) begin
          wb_kill      = exc_now;
          stall_pc     = 1'b1;
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
          flush_mem_wb = 1'b1;
        end else if (eret_now) begin
          pc_sel       = PC_EPC;
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
        end else if (lu_now) begin
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
        end
      end
      FLUSH: begin
        stall_pc     = 1'b1;
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
        flush_ex_mem = 1'b1;
        flush_mem_wb = 1'b1;
      end
      REDIRECT: begin
        pc_sel      = PC_HANDLER;
        flush_if_id = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      flush_cnt <= 3'd0;
    end else begin
      case (state)
        RUN: begin
          if (exc_now || int_now) begin
            state     <= FLUSH;
            flush_cnt <= 3'd0;
          end
        end
        FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state     <= REDIRECT;
            flush_cnt <= 3'd0;
          end else begin
            flush_cnt <= flush_cnt + 3'd1;
          end
        end
        REDIRECT: state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

  // Taking the interrupt consumes the pending request even if irq is still high this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_pend  <= 1'b0;
      epc_out   <= 32'd0;
      cause_out <= 5'd0;
    end else begin
      if (int_now) begin
        irq_pend <= 1'b0;
      end else if (irq) begin
        irq_pend <= 1'b1;
      end
      if (exc_now) begin
        epc_out   <= mem_wb_opc;
        cause_out <= mem_wb_overflow ? EXC_OV_CODE : mem_wb_exccode;
      end else if (int_now) begin
        epc_out   <= mem_wb_opc + 32'd4;
        cause_out <= EXC_INT_CODE;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      exc_cnt   <= 32'd0;
    end else begin
      if (lu_now && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if ((exc_now || int_now) && (exc_cnt != 32'hFFFF_FFFF)) begin
        exc_cnt <= exc_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed table-driven bench for pipe_hazard_ctrl, plus hand sequences for
// exception, interrupt, ERET, priority and mid-sequence reset (HAZARD_PERF_EN aware).
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, id_ex_rt, mem_wb_exccode;
  logic [2:0]  id_ex_memread;
  logic        mem_wb_valid, mem_wb_overflow, mem_wb_eret, irq;
  logic [31:0] mem_wb_opc;
  logic        stall_pc, stall_if_id, flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
  logic        wb_kill, busy;
  logic [1:0]  pc_sel;
  logic [31:0] epc_out;
  logic [4:0]  cause_out;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, exc_cnt;
`endif

  int compared = 0;
  int mismatched = 0;

  pipe_hazard_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_ex_memread   (id_ex_memread),
    .id_ex_rt        (id_ex_rt),
    .mem_wb_valid    (mem_wb_valid),
    .mem_wb_overflow (mem_wb_overflow),
    .mem_wb_exccode  (mem_wb_exccode),
    .mem_wb_opc      (mem_wb_opc),
    .mem_wb_eret     (mem_wb_eret),
    .irq             (irq),
    .stall_pc        (stall_pc),
    .stall_if_id     (stall_if_id),
    .flush_if_id     (flush_if_id),
    .flush_id_ex     (flush_id_ex),
    .flush_ex_mem    (flush_ex_mem),
    .flush_mem_wb    (flush_mem_wb),
    .wb_kill         (wb_kill),
    .pc_sel          (pc_sel),
    .epc_out         (epc_out),
    .cause_out       (cause_out),
    .busy            (busy)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt       (stall_cnt),
    .exc_cnt         (exc_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] memread;
    logic [4:0] exrt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       valid;
    logic [9:0] expCtl;
  } vec_t;

  // Control bundle order: stall_pc, stall_if_id, flush_if_id, flush_id_ex,
  // flush_ex_mem, flush_mem_wb, wb_kill, pc_sel[1:0], busy
  function automatic logic [9:0] ctl(input logic sp, input logic sif, input logic fif,
                                     input logic fid, input logic fex, input logic fmw,
                                     input logic wk, input logic [1:0] ps, input logic bz);
    return {sp, sif, fif, fid, fex, fmw, wk, ps, bz};
  endfunction

  function automatic vec_t mkVec(input string n, input logic [2:0] mr, input logic [4:0] er,
                                 input logic [4:0] rs, input logic [4:0] rt, input logic v,
                                 input logic [9:0] e);
    vec_t x;
    x.name = n; x.memread = mr; x.exrt = er; x.rs = rs; x.rt = rt; x.valid = v; x.expCtl = e;
    return x;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [9:0] exp);
    @(negedge clk);
    check32(name, 32'({stall_pc, stall_if_id, flush_if_id, flush_id_ex, flush_ex_mem,
                       flush_mem_wb, wb_kill, pc_sel, busy}), 32'(exp));
  endtask

  task automatic idleInputs();
    id_rs = 5'd0; id_rt = 5'd0; id_ex_memread = 3'd0; id_ex_rt = 5'd0;
    mem_wb_valid = 1'b0; mem_wb_overflow = 1'b0; mem_wb_exccode = 5'd0;
    mem_wb_opc = 32'd0; mem_wb_eret = 1'b0; irq = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    nextCycle();
    idleInputs();
    id_ex_memread = v.memread;
    id_ex_rt      = v.exrt;
    id_rs         = v.rs;
    id_rt         = v.rt;
    mem_wb_valid  = v.valid;
    mem_wb_opc    = 32'h0000_2000;
  endtask

  localparam logic [9:0] CTL_IDLE  = 10'b0;
  localparam logic [9:0] CTL_LU    = 10'b11_0100_0_00_0;
  localparam logic [9:0] CTL_EXC   = 10'b10_1111_1_00_0;
  localparam logic [9:0] CTL_INT   = 10'b10_1111_0_00_0;
  localparam logic [9:0] CTL_FLUSH = 10'b10_1111_0_00_1;
  localparam logic [9:0] CTL_REDIR = 10'b00_1000_0_01_1;
  localparam logic [9:0] CTL_ERET  = 10'b00_1110_0_10_0;

  vec_t vecs[10];

  initial begin
    vecs[0] = mkVec("lu_rs_match",   3'b001, 5'd5,  5'd5,  5'd0,  1'b0, ctl(1,1,0,1,0,0,0,2'b00,0));
    vecs[1] = mkVec("lu_released",   3'b000, 5'd0,  5'd5,  5'd0,  1'b0, CTL_IDLE);
    vecs[2] = mkVec("lu_rt_zero",    3'b001, 5'd0,  5'd0,  5'd0,  1'b0, CTL_IDLE);
    vecs[3] = mkVec("lu_rt_match",   3'b100, 5'd7,  5'd3,  5'd7,  1'b0, CTL_LU);
    vecs[4] = mkVec("no_load",       3'b000, 5'd7,  5'd3,  5'd7,  1'b0, CTL_IDLE);
    vecs[5] = mkVec("load_no_dep",   3'b010, 5'd9,  5'd8,  5'd10, 1'b0, CTL_IDLE);
    vecs[6] = mkVec("lu_r31_both",   3'b111, 5'd31, 5'd31, 5'd31, 1'b0, CTL_LU);
    vecs[7] = mkVec("lu_again",      3'b001, 5'd5,  5'd5,  5'd0,  1'b0, CTL_LU);
    vecs[8] = mkVec("idle",          3'b000, 5'd0,  5'd0,  5'd0,  1'b0, CTL_IDLE);
    vecs[9] = mkVec("lu_valid_noex", 3'b001, 5'd12, 5'd1,  5'd12, 1'b1, CTL_LU);

    idleInputs();
    rst = 1'b1;
    repeat (3) nextCycle();
    rst = 1'b0;
    checkOutput("reset_ctl", CTL_IDLE);
    check32("reset_epc", epc_out, 32'd0);
    check32("reset_cause", 32'(cause_out), 32'd0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i].name, vecs[i].expCtl);
    end
`ifdef HAZARD_PERF_EN
    nextCycle(); idleInputs();
    @(negedge clk);
    check32("perf_stall_cnt", stall_cnt, 32'd5);
`endif

    // Overflow exception and redirect two cycles later
    nextCycle(); idleInputs();
    mem_wb_valid = 1'b1; mem_wb_overflow = 1'b1; mem_wb_opc = 32'h0000_3010;
    checkOutput("ov_detect", CTL_EXC);
    nextCycle(); idleInputs();
    checkOutput("ov_flush", CTL_FLUSH);
    check32("ov_epc", epc_out, 32'h0000_3010);
    check32("ov_cause", 32'(cause_out), 32'd12);
    nextCycle();
    checkOutput("ov_redirect", CTL_REDIR);
    nextCycle();
    checkOutput("ov_back_run", CTL_IDLE);

    // Interrupt: pending across a NOP, taken on the next valid instruction
    nextCycle(); irq = 1'b1;
    checkOutput("irq_on_nop", CTL_IDLE);
    nextCycle(); irq = 1'b0;
    checkOutput("irq_pend_nop", CTL_IDLE);
    nextCycle(); mem_wb_valid = 1'b1; mem_wb_opc = 32'h0000_3020;
    checkOutput("int_take", CTL_INT);
    nextCycle(); idleInputs();
    checkOutput("int_flush", CTL_FLUSH);
    check32("int_epc", epc_out, 32'h0000_3024);
    check32("int_cause", 32'(cause_out), 32'd0);
    nextCycle();
    checkOutput("int_redirect", CTL_REDIR);
    nextCycle(); mem_wb_valid = 1'b1; mem_wb_opc = 32'h0000_3040;
    checkOutput("irq_pend_cleared", CTL_IDLE);

    // ERET returns to the saved EPC without leaving RUN
    nextCycle(); idleInputs(); mem_wb_valid = 1'b1; mem_wb_eret = 1'b1;
    checkOutput("eret", CTL_ERET);
    check32("eret_epc", epc_out, 32'h0000_3024);
    nextCycle(); idleInputs();
    checkOutput("eret_done", CTL_IDLE);

    // Exception beats ERET and load-use; ERET held high is ignored while busy
    nextCycle();
    mem_wb_valid = 1'b1; mem_wb_exccode = 5'd10; mem_wb_eret = 1'b1; mem_wb_opc = 32'h0000_3030;
    id_ex_memread = 3'b001; id_ex_rt = 5'd5; id_rs = 5'd5;
    checkOutput("simul_detect", CTL_EXC);
    nextCycle();
    checkOutput("simul_flush", CTL_FLUSH);
    check32("simul_cause", 32'(cause_out), 32'd10);
    check32("simul_epc", epc_out, 32'h0000_3030);
    nextCycle();
    checkOutput("simul_redirect", CTL_REDIR);
    nextCycle(); idleInputs();
    checkOutput("simul_back_run", CTL_IDLE);
`ifdef HAZARD_PERF_EN
    check32("perf_exc_cnt", exc_cnt, 32'd3);
    check32("perf_stall_hold", stall_cnt, 32'd5);
`endif

    // Reset in the middle of FLUSH: back to RUN with no redirect
    nextCycle(); mem_wb_valid = 1'b1; mem_wb_overflow = 1'b1; mem_wb_opc = 32'h0000_3050;
    checkOutput("rst_seq_detect", CTL_EXC);
    nextCycle(); idleInputs(); rst = 1'b1;
    nextCycle(); rst = 1'b0;
    checkOutput("rst_seq_run", CTL_IDLE);
    check32("rst_seq_epc", epc_out, 32'd0);
    check32("rst_seq_cause", 32'(cause_out), 32'd0);
    nextCycle();
    checkOutput("rst_seq_no_redirect", CTL_IDLE);
`ifdef HAZARD_PERF_EN
    check32("rst_stall_cnt", stall_cnt, 32'd0);
    check32("rst_exc_cnt", exc_cnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
